// File: rtl/fifo_ctrl_ptr.sv
// FIFO controller: occupancy FSM, wrapping RAM pointers, registered flags, synchronous flush.
// Optional sticky overflow/underflow logic is built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl_ptr #(
    parameter int unsigned depth    = 16,
    parameter int unsigned af_level = depth - 2,
    parameter int unsigned ae_level = 2,
    localparam int unsigned AW = ($clog2(depth) > 1) ? $clog2(depth) : 1,
    localparam int unsigned CW = $clog2(depth) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic          err_clr,
    output logic          wr_en,
    output logic          rd_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StEmpty;
            count_q   <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
        end
    end

    // Next occupancy, pointers and flags are all derived from count_d so flags never lag count.
    always_comb begin
        count_d   = count_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        if (flush) begin
            count_d   = '0;
            wr_addr_d = '0;
            rd_addr_d = '0;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en) begin
                wr_addr_d = (wr_addr_q == AW'(depth - 1)) ? '0 : wr_addr_q + AW'(1);
            end
            if (rd_en) begin
                rd_addr_d = (rd_addr_q == AW'(depth - 1)) ? '0 : rd_addr_q + AW'(1);
            end
        end
        af_d = (count_d >= CW'(af_level));
        ae_d = (count_d <= CW'(ae_level));
    end

    always_comb begin
        if (flush || count_d == '0) begin
            state_d = StEmpty;
        end else if (count_d == CW'(depth)) begin
            state_d = StFull;
        end else begin
            state_d = StPartial;
        end
    end

    // Strobes are gated by reset so nothing reaches the RAM while held in reset.
    always_comb begin
        full  = (state_q == StFull);
        empty = (state_q == StEmpty);
        wr_en = rst_i & push & ~flush & (~full | pop);
        rd_en = rst_i & pop & ~flush & ~empty;
    end

    assign wr_addr      = wr_addr_q;
    assign rd_addr      = rd_addr_q;
    assign count        = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

`ifdef FIFO_CTRL_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A fresh error in the clear cycle keeps the flag set.
    always_comb begin
        ovf_d = (push & ~flush & full & ~pop) | (ovf_q & ~err_clr);
        udf_d = (pop & ~flush & empty & ~push) | (udf_q & ~err_clr);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
